// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the front-end thread scheduler.
package thread_scheduler_pkg;

  localparam int unsigned n_threads = 8;
  localparam int unsigned epoch_w   = 2;

  typedef logic [$clog2(n_threads)-1:0] threadid_t;
  typedef logic [epoch_w-1:0]           epoch_t;
  typedef logic [31:0]                  vptr_t;

  localparam vptr_t reset_pc   = 32'h0000_1000;
  localparam vptr_t exc_vector = 32'h0000_2000;

endpackage

// File: rtl/thread_scheduler_if.sv
// Scheduler control/issue bundle. With SCHED_PERF_EN defined it also carries the
// per-thread issue counters and the idle-cycle counter.
interface thread_scheduler_if import thread_scheduler_pkg::*; #(
  parameter int unsigned N_THREADS = n_threads,
  parameter int unsigned EPOCH_W   = epoch_w
) ();
  localparam int unsigned ID_W = $clog2(N_THREADS);

  logic [N_THREADS-1:0]         thread_en;
  logic [N_THREADS-1:0]         stalled;
  logic [N_THREADS-1:0]         redirect_en;
  vptr_t                        redirect_pc;
  logic                         exc_en;
  logic [ID_W-1:0]              exc_thread;
  logic                         if_valid;
  logic [ID_W-1:0]              if_thread;
  vptr_t                        if_pc;
  logic [EPOCH_W-1:0]           if_epoch;
  logic [N_THREADS*32-1:0]      pc_all;
  logic [N_THREADS*EPOCH_W-1:0] epoch_all;
`ifdef SCHED_PERF_EN
  logic [N_THREADS*32-1:0]      perf_issue;
  logic [31:0]                  perf_idle;
`endif

  modport master (
    output thread_en, stalled, redirect_en, redirect_pc, exc_en, exc_thread,
`ifdef SCHED_PERF_EN
    input  perf_issue, perf_idle,
`endif
    input  if_valid, if_thread, if_pc, if_epoch, pc_all, epoch_all
  );

  modport slave (
    input  thread_en, stalled, redirect_en, redirect_pc, exc_en, exc_thread,
`ifdef SCHED_PERF_EN
    output perf_issue, perf_idle,
`endif
    output if_valid, if_thread, if_pc, if_epoch, pc_all, epoch_all
  );

endinterface

// File: rtl/thread_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request searching upward from i_ptr+1,
// wrapping modulo N (N must be a power of two).
module thread_scheduler_rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic                 o_grant_valid,
  output logic [$clog2(N)-1:0] o_grant_id
);
  localparam int unsigned ID_W = $clog2(N);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = '0;
    // i == N wraps back to i_ptr itself, so the last winner is considered last
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = i_ptr + ID_W'(i);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Round-robin thread scheduler feeding IF: owns per-thread PC/epoch, applies
// redirects and exception entry. Optional counters under SCHED_PERF_EN.
module thread_scheduler import thread_scheduler_pkg::*; #(
  parameter int unsigned N_THREADS  = n_threads,
  parameter vptr_t       RESET_PC   = reset_pc,
  parameter vptr_t       EXC_VECTOR = exc_vector,
  parameter int unsigned EPOCH_W    = epoch_w
) (
  input logic               clk,
  input logic               rst,
  thread_scheduler_if.slave bus
);
  localparam int unsigned ID_W = $clog2(N_THREADS);

  vptr_t              r_pc        [N_THREADS];
  vptr_t              w_pc_nxt    [N_THREADS];
  logic [EPOCH_W-1:0] r_epoch     [N_THREADS];
  logic [EPOCH_W-1:0] w_epoch_nxt [N_THREADS];

  logic [ID_W-1:0]    r_ptr;
  logic               r_if_valid;
  logic [ID_W-1:0]    r_if_thread;
  vptr_t              r_if_pc;
  logic [EPOCH_W-1:0] r_if_epoch;

  logic [N_THREADS-1:0] w_exc_oh;
  logic [N_THREADS-1:0] w_redir_oh;
  logic [N_THREADS-1:0] w_elig;
  logic [N_THREADS-1:0] w_issue_oh;
  logic                 w_grant_valid;
  logic [ID_W-1:0]      w_grant_id;
  vptr_t                w_redir_target;
  logic                 w_unused_pc_lsb;

  always_comb begin
    w_exc_oh = '0;
    if (bus.exc_en) w_exc_oh[bus.exc_thread] = 1'b1;
  end

  // Only the lowest set redirect bit is honoured; several set is illegal anyway
  assign w_redir_oh      = bus.redirect_en & (~bus.redirect_en + N_THREADS'(1));
  assign w_elig          = bus.thread_en & ~bus.stalled & ~bus.redirect_en & ~w_exc_oh;
  assign w_redir_target  = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^bus.redirect_pc[1:0];

  thread_scheduler_rr_arbiter #(
    .N (N_THREADS)
  ) u_rr_arbiter (
    .i_req         (w_elig),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  always_comb begin
    w_issue_oh = '0;
    if (w_grant_valid) w_issue_oh[w_grant_id] = 1'b1;
  end

  always_comb begin
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      w_pc_nxt[t]    = r_pc[t];
      w_epoch_nxt[t] = r_epoch[t];
      if (w_exc_oh[t]) begin
        w_pc_nxt[t]    = EXC_VECTOR;
        w_epoch_nxt[t] = r_epoch[t] + EPOCH_W'(1);
      end else if (w_redir_oh[t]) begin
        w_pc_nxt[t]    = w_redir_target;
        w_epoch_nxt[t] = r_epoch[t] + EPOCH_W'(1);
      end else if (w_issue_oh[t]) begin
        w_pc_nxt[t]    = r_pc[t] + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned t = 0; t < N_THREADS; t++) begin
        r_pc[t]    <= RESET_PC;
        r_epoch[t] <= '0;
      end
      r_ptr       <= ID_W'(N_THREADS - 1);
      r_if_valid  <= 1'b0;
      r_if_thread <= '0;
      r_if_pc     <= '0;
      r_if_epoch  <= '0;
    end else begin
      for (int unsigned t = 0; t < N_THREADS; t++) begin
        r_pc[t]    <= w_pc_nxt[t];
        r_epoch[t] <= w_epoch_nxt[t];
      end
      if (w_grant_valid) r_ptr <= w_grant_id;
      r_if_valid  <= w_grant_valid;
      r_if_thread <= w_grant_id;
      r_if_pc     <= r_pc[w_grant_id];
      r_if_epoch  <= r_epoch[w_grant_id];
    end
  end

  assign bus.if_valid  = r_if_valid;
  assign bus.if_thread = r_if_thread;
  assign bus.if_pc     = r_if_pc;
  assign bus.if_epoch  = r_if_epoch;

  // Thread 0 occupies the most significant slot of the packed views
  always_comb begin
    bus.pc_all    = '0;
    bus.epoch_all = '0;
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      bus.pc_all[(N_THREADS-1-t)*32 +: 32]         = r_pc[t];
      bus.epoch_all[(N_THREADS-1-t)*EPOCH_W +: EPOCH_W] = r_epoch[t];
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] r_perf_issue [N_THREADS];
  logic [31:0] r_perf_idle;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned t = 0; t < N_THREADS; t++) r_perf_issue[t] <= '0;
      r_perf_idle <= '0;
    end else begin
      for (int unsigned t = 0; t < N_THREADS; t++) begin
        if (w_issue_oh[t] && (r_perf_issue[t] != '1)) r_perf_issue[t] <= r_perf_issue[t] + 32'd1;
      end
      if (!w_grant_valid && (r_perf_idle != '1)) r_perf_idle <= r_perf_idle + 32'd1;
    end
  end

  always_comb begin
    bus.perf_issue = '0;
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      bus.perf_issue[(N_THREADS-1-t)*32 +: 32] = r_perf_issue[t];
    end
  end
  assign bus.perf_idle = r_perf_idle;
`endif

  a_redirect_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.redirect_en));

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: vector table through a scoreboard
// queue, then hand-written epoch-wrap and single-thread sequences.
module tb_thread_scheduler;
  import thread_scheduler_pkg::*;

  typedef struct {
    logic        rst_n;
    logic [7:0]  en, stl, rdr;
    logic [31:0] rpc;
    logic        exc;
    logic [2:0]  exct;
    logic        v;
    logic [2:0]  th;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        chk;
    logic [2:0]  ct;
    logic [31:0] cpc;
    logic [1:0]  cep;
    int          idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  thread_scheduler_if #(.N_THREADS(8), .EPOCH_W(2)) bus ();

  thread_scheduler u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic row(input logic rst_n, input logic [7:0] en, input logic [7:0] stl,
                     input logic [7:0] rdr, input logic [31:0] rpc, input logic exc,
                     input logic [2:0] exct, input logic v, input logic [2:0] th,
                     input logic [31:0] pc, input logic [1:0] ep, input logic chk,
                     input logic [2:0] ct, input logic [31:0] cpc, input logic [1:0] cep);
    vec_t r;
    r.rst_n = rst_n; r.en = en; r.stl = stl; r.rdr = rdr; r.rpc = rpc;
    r.exc = exc; r.exct = exct; r.v = v; r.th = th; r.pc = pc; r.ep = ep;
    r.chk = chk; r.ct = ct; r.cpc = cpc; r.cep = cep; r.idx = vecs.size();
    vecs.push_back(r);
  endtask

  task automatic iss(input logic [7:0] stl, input logic [2:0] th, input logic [31:0] pc,
                     input logic [1:0] ep);
    row(1, 8'hFF, stl, 8'h00, 0, 0, 0, 1, th, pc, ep, 0, 0, 0, 0);
  endtask

  task automatic rst_row();
    row(0, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic compare(input vec_t e);
    check($sformatf("row%0d if_valid", e.idx), 32'(bus.if_valid), 32'(e.v));
    if (e.v || !e.rst_n) begin
      check($sformatf("row%0d if_thread", e.idx), 32'(bus.if_thread), 32'(e.th));
      check($sformatf("row%0d if_pc", e.idx), bus.if_pc, e.pc);
      check($sformatf("row%0d if_epoch", e.idx), 32'(bus.if_epoch), 32'(e.ep));
    end
    if (e.chk) begin
      check($sformatf("row%0d pc_all[t%0d]", e.idx, e.ct), bus.pc_all[(7-e.ct)*32 +: 32], e.cpc);
      check($sformatf("row%0d epoch_all[t%0d]", e.idx, e.ct),
            32'(bus.epoch_all[(7-e.ct)*2 +: 2]), 32'(e.cep));
    end
  endtask

  task automatic drive(input logic rst_n, input logic [7:0] en, input logic [7:0] stl,
                       input logic [7:0] rdr, input logic [31:0] rpc, input logic exc,
                       input logic [2:0] exct);
    rst = rst_n; bus.thread_en = en; bus.stalled = stl; bus.redirect_en = rdr;
    bus.redirect_pc = rpc; bus.exc_en = exc; bus.exc_thread = exct;
  endtask

  initial begin
    bit seen;
    drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    // Reset with requests pending: reset must win
    row(0, 8'hFF, 8'h00, 8'h01, 32'h5555, 1, 3, 0, 0, 0, 0, 1, 3, 32'h1000, 0);
    for (int i = 0; i < 8; i++) iss(8'h00, 3'(i), 32'h1000, 0);
    row(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, 0, 32'h1004, 0, 1, 0, 32'h1008, 0);

    // Steady stall of threads 1 and 2
    rst_row();
    iss(8'h06, 0, 32'h1000, 0);
    for (int i = 3; i < 7; i++) iss(8'h06, 3'(i), 32'h1000, 0);
    row(1, 8'hFF, 8'h06, 8'h00, 0, 0, 0, 1, 7, 32'h1000, 0, 1, 2, 32'h1000, 0);
    row(1, 8'hFF, 8'h06, 8'h00, 0, 0, 0, 1, 0, 32'h1004, 0, 1, 1, 32'h1000, 0);

    // Redirect of thread 3 in the cycle it would issue
    rst_row();
    for (int i = 0; i < 3; i++) iss(8'h00, 3'(i), 32'h1000, 0);
    row(1, 8'hFF, 8'h00, 8'h08, 32'h4003, 0, 0, 1, 4, 32'h1000, 0, 1, 3, 32'h4000, 1);
    for (int i = 5; i < 8; i++) iss(8'h00, 3'(i), 32'h1000, 0);
    for (int i = 0; i < 3; i++) iss(8'h00, 3'(i), 32'h1004, 0);
    row(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, 3, 32'h4000, 1, 1, 3, 32'h4004, 1);

    // Exception beats redirect on one thread; events on different threads both apply
    rst_row();
    row(1, 8'hFF, 8'h00, 8'h20, 32'h7777_0000, 1, 5, 1, 0, 32'h1000, 0, 1, 5, 32'h2000, 1);
    row(1, 8'hFF, 8'h00, 8'h02, 32'h3000, 1, 6, 1, 2, 32'h1000, 0, 1, 1, 32'h3000, 1);
    row(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, 3, 32'h1000, 0, 1, 6, 32'h2000, 1);
    iss(8'h00, 4, 32'h1000, 0);
    iss(8'h00, 5, 32'h2000, 1);
    iss(8'h00, 6, 32'h2000, 1);
    iss(8'h00, 7, 32'h1000, 0);
    iss(8'h00, 0, 32'h1004, 0);
    iss(8'h00, 1, 32'h3000, 1);

    // Nothing eligible, then only thread 6 released
    rst_row();
    row(1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1000, 0);
    for (int i = 0; i < 4; i++)
      row(1, 8'hFF, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 3'(i), 32'h1000, 0);
    iss(8'hBF, 6, 32'h1000, 0);
    iss(8'hBF, 6, 32'h1004, 0);

    // PC wrap at the top of the address space
    rst_row();
    row(1, 8'hFF, 8'h00, 8'h04, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h1000, 0, 1, 2, 32'hFFFF_FFFC, 1);
    iss(8'h00, 1, 32'h1000, 0);
    row(1, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 1, 2, 32'hFFFF_FFFC, 1, 1, 2, 32'h0000_0000, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (sb.size() > 0) compare(sb.pop_front());
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].stl, vecs[i].rdr, vecs[i].rpc,
            vecs[i].exc, vecs[i].exct);
      sb.push_back(vecs[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) compare(sb.pop_front());

    // Epoch wraps modulo 4 after four redirects of thread 0
    drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'h00, 8'h00, 8'h01, 32'h0000_0100, 0, 0);
      @(negedge clk);
      check($sformatf("wrap%0d epoch_all[t0]", k), 32'(bus.epoch_all[15:14]), 32'(k % 4));
      check($sformatf("wrap%0d pc_all[t0]", k), bus.pc_all[255:224], 32'h0000_0100);
    end

    // Only thread 5 enabled: wait (bounded) for it, then consecutive issues
    drive(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    @(negedge clk);
    drive(1, 8'h20, 8'h00, 8'h00, 0, 0, 0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.if_valid;
    end
    check("solo wait if_valid", 32'(seen), 32'd1);
    check("solo if_thread", 32'(bus.if_thread), 32'd5);
    check("solo if_pc first", bus.if_pc, 32'h1000);
    @(negedge clk);
    check("solo if_pc second", bus.if_pc, 32'h1004);
    check("solo epoch_all", 32'(bus.epoch_all), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
